// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a shifting
// accumulator, signed/unsigned per operation, valid/ready on both sides.
module booth_r4_seq_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P,
    output logic           O
);

    localparam int CW  = $clog2(N/2+2);
    localparam int AW  = N + 2;       // extended operand width
    localparam int SW  = N + 3;       // partial product / sum width
    localparam int ACW = 2*N + 4;     // accumulator width
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N/2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW:0]      mpl_q, mpl_d;
    logic [ACW-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   p_q, p_d;
    logic             o_q, o_d;
    logic             sgn_q, sgn_d;

    logic [AW-1:0]    a_ext, b_ext;
    logic [2:0]       digit;
    logic [SW-1:0]    pp_mag;
    logic             pp_neg;
    logic [SW-1:0]    acc_hi;
    logic [SW-1:0]    sum;
    logic [ACW:0]     acc_pre;
    logic [ACW-1:0]   acc_step;
    logic [2*N-1:0]   p_step;
    logic [N:0]       p_hi_s;
    logic             ovf_step;

    assign a_ext = signed_mode ? {{2{A[N-1]}}, A} : {2'b00, A};
    assign b_ext = signed_mode ? {{2{B[N-1]}}, B} : {2'b00, B};

    // Booth recoding of multiplier bits (2i+1, 2i, 2i-1).
    assign digit = mpl_q[2:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pp_mag = '0;
        pp_neg = 1'b0;
        case (digit)
            3'b001, 3'b010: pp_mag = {a_q[AW-1], a_q};
            3'b011:         pp_mag = {a_q, 1'b0};
            3'b100: begin
                pp_mag = {a_q, 1'b0};
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag = {a_q[AW-1], a_q};
                pp_neg = 1'b1;
            end
            default: ;
        endcase
    end

    // Sum is one bit wider than the register slice it replaces, so the
    // transient before the 2-bit shift cannot wrap; the shift drops that bit.
    assign acc_hi   = {acc_q[ACW-1], acc_q[ACW-1:N+2]};
    assign sum      = acc_hi + (pp_neg ? ~pp_mag : pp_mag) + SW'(pp_neg);
    assign acc_pre  = {sum, acc_q[N+1:0]};
    assign acc_step = ACW'($signed(acc_pre) >>> 2);

    assign p_step   = acc_step[2*N-1:0];
    assign p_hi_s   = p_step[2*N-1:N-1];
    assign ovf_step = sgn_q ? ~((&p_hi_s) | ~(|p_hi_s)) : (|p_step[2*N-1:N]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        mpl_d   = mpl_q;
        acc_d   = acc_q;
        p_d     = p_q;
        o_d     = o_q;
        sgn_d   = sgn_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = a_ext;
                        mpl_d   = {b_ext, 1'b0};
                        sgn_d   = signed_mode;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    mpl_d = {2'b00, mpl_q[AW:2]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        p_d     = p_step;
                        o_d     = ovf_step;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            mpl_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            o_q     <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            mpl_q   <= mpl_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            o_q     <= o_d;
            sgn_q   <= sgn_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign P         = p_q;
    assign O         = o_q;

endmodule
